// File: rtl/serial_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_assembler
// Description : Collects a registered serial bit stream one bit per clock.
//               It packs WIDTH bits into a word, with the first bit received
//               in the MSB. The word is presented to the consumer through a
//               valid/ready handshake.
//               Optional even-parity check: define
//               SERIAL_WORD_ASSEMBLER_PARITY_EN to enable it.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_assembler #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       din,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           word,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH+1);

  // Count value reached just before the final data bit is shifted in.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_HOLD   = 2'd2,
    S_PARITY = 2'd3
  } state_t;

  state_t state;

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  logic parity_err_r;
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  // Capture state machine. All outputs are registered here, so there is no
  // combinational path from din to any output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      word      <= '0;
      bit_count <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // din is ignored here; word keeps the last delivered value.
          if (start) begin
            state     <= S_SHIFT;
            word      <= '0;
            bit_count <= '0;
            busy      <= 1'b1;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
            parity_err_r <= 1'b0;
`endif
          end
        end

        S_SHIFT: begin
          // start is ignored while shifting.
          word      <= {word[WIDTH-2:0], din};
          bit_count <= bit_count + CNT_ONE;
          if (bit_count == LAST_IDX) begin
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
            // Spend one more cycle sampling the parity bit; busy stays high.
            state <= S_PARITY;
`else
            state     <= S_HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
`endif
          end
        end

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        S_PARITY: begin
          // Even parity: the data ones plus the parity bit must be even.
          parity_err_r <= (^word) ^ din;
          state        <= S_HOLD;
          busy         <= 1'b0;
          out_valid    <= 1'b1;
        end
`endif

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              // Back-to-back: start the next word with no idle cycle between.
              state     <= S_SHIFT;
              word      <= '0;
              bit_count <= '0;
              busy      <= 1'b1;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
              parity_err_r <= 1'b0;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_assembler
// Description : Self-checking bench for serial_word_assembler.
//               Directed scenarios run first, then a randomized run. Every
//               output is compared against a transaction-level model that
//               keeps the captured bits in a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_assembler;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, din, out_ready;
  logic             out_valid, busy, parity_err;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bit_count;

  serial_word_assembler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .out_ready(out_ready), .out_valid(out_valid), .word(word),
    .busy(busy), .bit_count(bit_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model. Phases: 0 idle, 1 capturing, 2 parity, 3 holding.
  int  m_phase = 0;
  bit  m_bits[$];
  bit  m_perr  = 1'b0;

  function automatic logic [WIDTH-1:0] m_word();
    logic [WIDTH-1:0] w = '0;
    foreach (m_bits[i]) w = w * 2 + WIDTH'(m_bits[i]);
    return w;
  endfunction

  function automatic int m_ones();
    int n = 0;
    foreach (m_bits[i]) n += int'(m_bits[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit d, input bit rdy);
    if (r) begin
      m_phase = 0; m_bits.delete(); m_perr = 1'b0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_bits.delete(); m_perr = 1'b0; end
        1: begin
          m_bits.push_back(d);
          if (m_bits.size() == WIDTH) m_phase = PAR ? 2 : 3;
        end
        2: begin m_perr = bit'((m_ones() + int'(d)) % 2); m_phase = 3; end
        default: if (rdy) begin
          if (s) begin m_phase = 1; m_bits.delete(); m_perr = 1'b0; end
          else m_phase = 0;
        end
      endcase
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input bit r, input bit s, input bit d, input bit rdy);
    reset = r; start = s; din = d; out_ready = rdy;
    @(posedge clk);
    model_step(r, s, d, rdy);
    #1;
    check("out_valid",  32'(out_valid),  32'(m_phase == 3));
    check("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
    check("word",       32'(word),       32'(m_word()));
    check("bit_count",  32'(bit_count),  32'(m_bits.size()));
    check("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  // Send a full word (MSB first) plus the parity bit when that feature exists.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit pbit);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(0, 0, w[i], 0);
    if (PAR) cyc(0, 0, pbit, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 1'b0; out_ready = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("reset_word", 32'(word), 32'h0);

    // 1: reset in the middle of a capture.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check("t1_count3", 32'(bit_count), 32'd3);
    cyc(1, 0, 1, 0);
    check("t1_word", 32'(word), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);

    // 2: capture 0xB2 and hold it while the consumer is not ready.
    cyc(0, 1, 0, 0);
    send_word(8'hB2, 1'b0);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_word",  32'(word), 32'hB2);
    for (int i = 0; i < 5; i++) cyc(0, i[0], ~i[0], 0);
    check("t2_hold_word",  32'(word), 32'hB2);
    check("t2_hold_count", 32'(bit_count), 32'd8);

    // 3: handshake without start, then din toggling in idle.
    cyc(0, 0, 1, 1);
    check("t3_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, i[0], i[1]);
    check("t3_word", 32'(word), 32'hB2);

    // 4: back-to-back words.
    cyc(0, 1, 0, 0);
    send_word(8'hB2, 1'b0);
    cyc(0, 1, 0, 1);
    check("t4_busy", 32'(busy), 32'd1);
    send_word(8'h5A, 1'b0);
    check("t4_word",  32'(word), 32'h5A);
    check("t4_valid", 32'(out_valid), 32'd1);
    cyc(0, 0, 0, 1);

    // 5: start during shift is ignored.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    if (PAR) cyc(0, 0, 0, 0);
    check("t5_word",  32'(word), 32'hC3);
    check("t5_valid", 32'(out_valid), 32'd1);
    cyc(0, 0, 0, 1);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    // 6: parity good and bad; valid only one cycle after the last data bit.
    cyc(0, 1, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(0, 0, i == 7 || i == 5 || i == 4 || i == 1, 0);
    check("t6_not_yet_valid", 32'(out_valid), 32'd0);
    cyc(0, 0, 0, 0);
    check("t6_perr_good", 32'(parity_err), 32'd0);
    cyc(0, 1, 0, 1);
    send_word(8'hB2, 1'b1);
    check("t6_perr_bad", 32'(parity_err), 32'd1);
    cyc(0, 0, 0, 1);
`endif

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom), ($urandom_range(0, 2) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Downstream consumer of the single-bit enabled flip-flop stage (DESwitch).
- Samples the registered serial bit stream (its Q output) one bit per clock.
- Packs WIDTH bits into a parallel word and presents it with a valid/ready handshake.
- Feeds CDA3102 datapath labs that need a word-wide register load from a bit-serial source.

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- start  input  1  request to begin capturing a word; honoured only in IDLE, or in HOLD on the handshake cycle
- din  input  1  serial data bit (upstream flip-flop Q)
- out_ready  input  1  downstream accepts word when high with out_valid
- out_valid  output  1  word holds a complete word
- word  output  WIDTH  assembled word, first-received bit in MSB
- busy  output  1  high while in SHIFT (or PARITY when the optional feature is compiled in)
- bit_count  output  $clog2(WIDTH+1)  number of data bits captured so far in the current word
- parity_err  output  1  parity mismatch flag; constant 0 when the optional feature is absent

Behaviour:
- Single clock domain; reset is synchronous and active-high, as already decided. No asynchronous paths.
- Reset (reset=1 at a rising edge), taking priority over all other inputs, including mid-SHIFT and mid-HOLD:
  - state=IDLE.
  - word=0, bit_count=0, out_valid=0, busy=0, parity_err=0.
- States: IDLE, SHIFT, HOLD (plus PARITY with the optional feature).
- IDLE:
  - busy=0, out_valid=0.
  - On start=1: go to SHIFT, bit_count<=0, word<=0.
  - din is ignored in IDLE.
- SHIFT:
  - busy=1. Each rising edge: word<={word[WIDTH-2:0],din}, bit_count<=bit_count+1.
  - On the edge where bit_count becomes WIDTH: go to HOLD.
  - start is ignored in SHIFT.
- Latency:
  - start sampled at edge N; din sampled at edges N+1 .. N+WIDTH.
  - out_valid=1 immediately after edge N+WIDTH.
- HOLD:
  - out_valid=1, busy=0; word and bit_count (=WIDTH) held stable while out_ready=0.
  - Handshake at an edge with out_valid=1 and out_ready=1:
    - start=0: go to IDLE; out_valid<=0; word retains its value until the next start.
    - start=1 (back-to-back): go directly to SHIFT; bit_count<=0, word<=0; no IDLE bubble.
- Outputs are registered or decoded from the state register; no combinational path from din to any output.
- bit_count never exceeds WIDTH; there is no wrap.

Optional Feature:
- Macro: SERIAL_WORD_ASSEMBLER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, the FSM enters PARITY for one cycle (busy=1).
  - din is sampled there as an even-parity bit.
  - parity_err<=(^word)^din, then the FSM goes to HOLD. out_valid is therefore delayed by one cycle, to edge N+WIDTH+1.
  - parity_err holds its value through HOLD and clears on the next start or on reset.
- Not defined: no PARITY state and parity_err tied to 0.

Test Plan (WIDTH=8):
1. reset=1 for one edge while in SHIFT with bit_count=3 -> next cycle state IDLE, word=0, out_valid=0, busy=0, bit_count=0.
2. start pulse, din sequence 1,0,1,1,0,0,1,0 over the next 8 edges, out_ready=0 -> out_valid=1 after the 8th edge; word=8'hB2 held for 5 further cycles; bit_count=8.
3. HOLD with word=8'hB2, raise out_ready with start=0 -> one edge later out_valid=0, state IDLE; din toggling while IDLE leaves word=8'hB2.
4. Back-to-back: at the handshake edge, start=1 and out_ready=1, then din=8'h5A bits -> busy=1 the cycle right after the handshake; second word 8'h5A valid 8 edges later.
5. start asserted during SHIFT (after 4 bits) -> ignored; word completes normally after 8 bits total.
6. With SERIAL_WORD_ASSEMBLER_PARITY_EN: data 8'hB2 (four ones) with parity bit 0 -> parity_err=0; same data with parity bit 1 -> parity_err=1; out_valid asserted at edge N+9.
